prog_loader: RTL

- Writer side of the SAP program-memory interface.
- Accepts a byte stream over a valid/ready handshake and stores it in a 16x8 program RAM.
- The CPU reads the RAM through the same address/CE_ port as the ROM, and the RAM drives the shared 8-bit bus.
- Holds the CPU in clear while a load is in progress and releases it when the image is complete.

---
 rtl/sap_pkg.sv | 15 +
 rtl/prog_ram.sv | 30 +++
 rtl/prog_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Constants and loader state type shared across the SAP datapath blocks (MAR, ROM, IR, program loader).
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } ld_state_t;

endpackage

// File: rtl/prog_ram.sv
// DEPTH x DATA_W program RAM: synchronous write, asynchronous read, tri-state output gated by the active-low ce_n.
module prog_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ce_n,
  output wire  [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wipes every word so that an aborted load leaves no partial image behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ce_n ? {DATA_W{1'bz}} : mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// SAP program loader: streams bytes into prog_ram and holds the CPU in clear until the image is complete.
// Optional trailing-checksum verification is enabled with the PROG_LOADER_CHECKSUM_EN macro.
module prog_loader
  import sap_pkg::*;
#(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic              CE_,
  output wire  [DATA_W-1:0] RAM_Out,
  output logic              cpu_clr,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   load_count
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam ld_state_t LOAD_DONE = CHECK;
`else
  localparam ld_state_t LOAD_DONE = RUN;
`endif

  ld_state_t         state;
  ld_state_t         state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              mem_we;
  logic              last_byte;
  logic              load_entry;

  assign last_byte  = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign load_entry = (state != LOAD) && (state_nx == LOAD);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nx;

  assign sum_nx = sum + in_data;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        mem_we   = in_valid;
        if (in_valid && last_byte) state_nx = LOAD_DONE;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nx = (sum_nx == '0) ? RUN : ERROR;
      end
      ERROR: begin
        if (start) state_nx = LOAD;
      end
`endif
      RUN: begin
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointer and count restart on every entry to LOAD; cpu_clr follows the next state so it is glitch-free.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr     <= '0;
      load_count <= '0;
      cpu_clr    <= 1'b0;
    end else begin
      cpu_clr <= (state_nx == RUN);
      if (load_entry) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (mem_we) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      err <= (state_nx == ERROR);
      if (load_entry)                 sum <= '0;
      else if (in_valid && in_ready)  sum <= sum_nx;
    end
  end
`else
  assign err = 1'b0;
`endif

  prog_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (CLK),
    .rst_n(CLR),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(address),
    .ce_n (CE_),
    .rdata(RAM_Out)
  );

endmodule
